// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RV32I control unit.
// Moore FSM sequencing fetch/decode/execute/memory/writeback, plus the ALU-op
// and immediate-format decoders that drive the datapath selects.
module mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    state_e     state_q, state_d;
    logic [1:0] alu_op;

    // Raw strobes before the reset gate.
    logic pc_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic mem_write_raw;
    logic instr_done_raw;
    logic illegal_raw;

    // Opcode legality classification used only by DECODE.
    logic f3_alu_ok;
    logic dec_mem;
    logic dec_rtype;
    logic dec_itype;
    logic dec_beq;
    logic dec_jal;

    // Classify the current instruction word into the supported subset.
    always_comb begin
        f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b011) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
        dec_mem   = ((op == OpLoad) || (op == OpStore)) && (funct3 == 3'b010);
        // funct7 bit 5 only selects sub; for sltu/or/and it must be clear.
        dec_rtype = (op == OpRType) && f3_alu_ok &&
                    ((funct3 == 3'b000) || !funct7b5);
        dec_itype = (op == OpIType) && f3_alu_ok;
        dec_beq   = (op == OpBeq) && (funct3 == 3'b000);
        dec_jal   = (op == OpJal);
    end

    // State register; reset parks the FSM in FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; every field defaults to zero.
    always_comb begin
        state_d        = state_q;
        pc_write_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        mem_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        illegal_raw    = 1'b0;
        adr_src        = 1'b0;
        result_src     = 2'b00;
        alu_src_a      = 2'b00;
        alu_src_b      = 2'b00;
        alu_op         = 2'b00;

        case (state_q)
            StFetch: begin
                // PC + 4 goes straight onto the result bus into the PC.
                alu_src_a    = 2'b00;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // OldPC + imm lands in ALUOut as the branch/jump target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (dec_mem) begin
                    state_d = StMemAdr;
                end else if (dec_rtype) begin
                    state_d = StExecR;
                end else if (dec_itype) begin
                    state_d = StExecI;
                end else if (dec_beq) begin
                    state_d = StBeq;
                end else if (dec_jal) begin
                    state_d = StJal;
                end else begin
                    illegal_raw = 1'b1;
                    state_d     = StFetch;
                end
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src     = 2'b01;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = StFetch;
            end
            StMemWrite: begin
                // Strobe is held until memory accepts the store.
                adr_src        = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = mem_ready;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_d        = StFetch;
            end
            StBeq: begin
                // Target already sits in ALUOut; taken when rs1 - rs2 == 0.
                alu_src_a      = 2'b10;
                alu_src_b      = 2'b00;
                alu_op         = 2'b01;
                pc_write_raw   = zero;
                instr_done_raw = 1'b1;
                state_d        = StFetch;
            end
            StJal: begin
                // PC <- ALUOut (target) while the ALU forms OldPC + 4 for rd.
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = StAluWb;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // ALU command from alu_op and the funct fields.
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type (op[5] set) may select sub.
                    3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b011:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OpLoad, OpIType: imm_src = 2'b00;
            OpStore:         imm_src = 2'b01;
            OpBeq:           imm_src = 2'b10;
            OpJal:           imm_src = 2'b11;
            default:         imm_src = 2'b00;
        endcase
    end

    // Enables are held low for as long as reset is asserted.
    assign pc_write      = rst_n & pc_write_raw;
    assign ir_write      = rst_n & ir_write_raw;
    assign reg_write     = rst_n & reg_write_raw;
    assign mem_write     = rst_n & mem_write_raw;
    assign instr_done    = rst_n & instr_done_raw;
    assign illegal_instr = rst_n & illegal_raw;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream against an
// instruction-level model of cycle counts, strobes and ALU commands.
`timescale 1ns/1ps
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_instr;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int ClsLw = 0, ClsSw = 1, ClsR = 2, ClsI = 3, ClsBeq = 4,
                   ClsJal = 5, ClsIll = 6;

    mc_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .adr_src      (adr_src),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .result_src   (result_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .imm_src      (imm_src),
        .alu_control  (alu_control),
        .instr_done   (instr_done),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Instruction class from the supported-subset rules.
    function automatic int classify(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bit alu_f3 = (f3 == 3'b000) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (o == 7'b0000011 && f3 == 3'b010) return ClsLw;
        if (o == 7'b0100011 && f3 == 3'b010) return ClsSw;
        if (o == 7'b0110011 && alu_f3 && (f3 == 3'b000 || !f7)) return ClsR;
        if (o == 7'b0010011 && alu_f3) return ClsI;
        if (o == 7'b1100011 && f3 == 3'b000) return ClsBeq;
        if (o == 7'b1101111) return ClsJal;
        return ClsIll;
    endfunction

    function automatic logic [2:0] exp_alu(input int c, input logic [2:0] f3, input logic f7);
        if (c == ClsBeq) return 3'b001;
        if (c == ClsR || c == ClsI) begin
            case (f3)
                3'b000:  return (c == ClsR && f7) ? 3'b001 : 3'b000;
                3'b011:  return 3'b101;
                3'b110:  return 3'b011;
                3'b111:  return 3'b010;
                default: return 3'b000;
            endcase
        end
        return 3'b000;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int base_cycles(input int c);
        case (c)
            ClsLw:   return 5;
            ClsSw:   return 4;
            ClsBeq:  return 3;
            ClsIll:  return 2;
            default: return 4;
        endcase
    endfunction

    // Run one instruction from FETCH. fw = ready-low cycles in FETCH,
    // mw = ready-low cycles in the memory access. Entered at posedge + 1.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw);
        int  c       = classify(o, f3, f7);
        bit  has_mem = (c == ClsLw) || (c == ClsSw);
        bit  has_ex  = has_mem || (c == ClsR) || (c == ClsI) || (c == ClsBeq);
        bit  has_rw  = (c == ClsLw) || (c == ClsR) || (c == ClsI) || (c == ClsJal);
        int  mstart  = fw + 3;
        int  exp_cyc = base_cycles(c) + fw + (has_mem ? mw : 0);
        int  exp_pc  = 1 + ((c == ClsBeq && z) ? 1 : 0) + ((c == ClsJal) ? 1 : 0);
        int  cyc = 0, n_ir = 0, ir_cyc = -1, n_rw = 0, n_mw = 0, n_pc = 0;
        int  n_ill = 0, n_ex = 0, n_done = 0;
        logic [1:0] rw_rs   = 2'b11;
        logic [2:0] ex_ctl  = 3'b111;
        logic [1:0] dec_imm = 2'b00;
        bit  done = 0;

        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        while (!done && cyc < 40) begin
            if (cyc < fw) mem_ready = 1'b0;
            else if (cyc == fw) mem_ready = 1'b1;
            else if (has_mem && cyc >= mstart && cyc < mstart + mw) mem_ready = 1'b0;
            else if (has_mem && cyc == mstart + mw) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ir_write) begin n_ir++; ir_cyc = cyc; end
            if (reg_write) begin n_rw++; rw_rs = result_src; end
            if (mem_write) n_mw++;
            if (pc_write) n_pc++;
            if (illegal_instr) n_ill++;
            if (alu_src_a == 2'b10) begin n_ex++; ex_ctl = alu_control; end
            if (cyc == fw + 1) dec_imm = imm_src;
            if (instr_done) n_done++;
            if (instr_done || illegal_instr) done = 1;
            cyc++;
            @(posedge clk);
            #1;
        end

        check_eq({name, "_cycles"}, cyc, exp_cyc);
        check_eq({name, "_ir_write_cnt"}, n_ir, 1);
        check_eq({name, "_ir_write_cyc"}, ir_cyc, fw);
        check_eq({name, "_reg_write_cnt"}, n_rw, has_rw ? 1 : 0);
        if (has_rw) check_eq({name, "_wb_result_src"}, rw_rs, (c == ClsLw) ? 2'b01 : 2'b00);
        check_eq({name, "_mem_write_cnt"}, n_mw, (c == ClsSw) ? mw + 1 : 0);
        check_eq({name, "_pc_write_cnt"}, n_pc, exp_pc);
        check_eq({name, "_illegal_cnt"}, n_ill, (c == ClsIll) ? 1 : 0);
        check_eq({name, "_done_cnt"}, n_done, (c == ClsIll) ? 0 : 1);
        check_eq({name, "_exec_cnt"}, n_ex, has_ex ? 1 : 0);
        if (has_ex) check_eq({name, "_alu_control"}, ex_ctl, exp_alu(c, f3, f7));
        check_eq({name, "_imm_src"}, dec_imm, exp_imm(o));
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_enables"},
                 {pc_write, ir_write, reg_write, mem_write, instr_done, illegal_instr}, 6'b0);
        check_eq({name, "_selects"},
                 {adr_src, alu_src_a, alu_src_b, result_src, alu_control},
                 {1'b0, 2'b00, 2'b10, 2'b10, 3'b000});
    endtask

    logic [6:0] ops_tbl [8];
    logic [2:0] f3_tbl  [4];

    initial begin
        ops_tbl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                    7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
        f3_tbl  = '{3'b000, 3'b011, 3'b110, 3'b111};

        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("sltu",  7'b0110011, 3'b011, 1'b0, 1'b0, 0, 0);
        run_instr("or",    7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
        run_instr("and",   7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
        run_instr("addi7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 2, 3);
        run_instr("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);
        run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0);

        // Reset abort during a stalled MEMREAD.
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check_eq("abort_memread_adr", adr_src, 1'b1);
        check_eq("abort_memread_rw", reg_write, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort_async");
        mem_ready = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("abort_held");
        rst_n = 1'b1;
        run_instr("post_abort", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [6:0] o  = ops_tbl[$urandom_range(0, 7)];
            logic [2:0] f3 = 3'($urandom);
            logic       f7 = 1'($urandom);
            logic       z  = 1'($urandom);
            if (ops_tbl[7] == o) o = 7'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (o == 7'b0000011 || o == 7'b0100011) f3 = 3'b010;
                else if (o == 7'b1100011) f3 = 3'b000;
                else if (o == 7'b0110011 || o == 7'b0010011) f3 = f3_tbl[$urandom_range(0, 3)];
            end
            run_instr("rand", o, f3, f7, z, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the RV32I subset core: a Moore FSM plus an ALU-op decoder that sequences fetch, decode, execute, memory and writeback. It sits directly upstream of the ALU and drives its 3-bit `alu_control` and operand-mux selects. It consumes the ALU `zero` flag for branches. It also gates the PC, IR, register-file and memory write enables, and waits on a memory ready handshake.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 7: IR[6:0].
- `funct3` input 3: IR[14:12].
- `funct7b5` input 1: IR[30].
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: PC register enable.
- `adr_src` output 1: memory address select; 0 = PC, 1 = result bus.
- `mem_write` output 1: data memory write strobe.
- `ir_write` output 1: IR and OldPC enable.
- `reg_write` output 1: register-file write enable.
- `result_src` output 2: result bus select; 00 = ALUOut reg, 01 = read data reg, 10 = ALU result.
- `alu_src_a` output 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rd1 reg.
- `alu_src_b` output 2: ALU B select; 00 = rd2 reg, 01 = imm_ext, 10 = constant 4.
- `imm_src` output 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` output 3: ALU command; 000 = add, 001 = sub, 010 = and, 011 = or, 101 = unsigned less-than.
- `instr_done` output 1: last cycle of an instruction.
- `illegal_instr` output 1: one-cycle pulse on an unsupported encoding.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL. All outputs are combinational from state and inputs. Any undefined state encoding goes to FETCH.
- Internal `alu_op`: 00 forces add, 01 forces sub, 10 decodes funct.
  - With `alu_op` = 10, funct3 000 gives sub when {op[5], funct7b5} = 11, otherwise add.
  - funct3 011 gives 101, 110 gives 011, and 111 gives 010.
- `imm_src` is decoded from `op` in every state: lw and ALU-I give 00, sw gives 01, beq gives 10, jal gives 11.
- FETCH:
  - Drives adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - Drives alu_src_a 01, alu_src_b 01, alu_op 00, so the branch target is computed into ALUOut.
  - Next state by opcode:
    - 0000011 with funct3 010, or 0100011 with funct3 010, goes to MEMADR.
    - 0110011 with funct3 in {000, 011, 110, 111}, and funct7 bit 5 allowed only for funct3 000, goes to EXECR.
    - 0010011 with funct3 in {000, 011, 110, 111} goes to EXECI.
    - 1100011 with funct3 000 goes to BEQ.
    - 1101111 goes to JAL.
    - Anything else asserts `illegal_instr` for this cycle and goes to FETCH.
- MEMADR: drives alu_src_a 10, alu_src_b 01, add. Goes to MEMREAD if `op[5]` = 0, otherwise MEMWRITE.
- MEMREAD: drives result_src 00, adr_src 1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: drives result_src 01, reg_write 1, `instr_done`. Goes to FETCH.
- MEMWRITE:
  - Drives result_src 00, adr_src 1.
  - `mem_write` stays asserted every cycle until `mem_ready`.
  - `instr_done` equals `mem_ready`.
  - Goes to FETCH on `mem_ready`.
- EXECR: drives alu_src_a 10, alu_src_b 00, alu_op 10. Goes to ALUWB.
- EXECI: drives alu_src_a 10, alu_src_b 01, alu_op 10. Goes to ALUWB.
- ALUWB: drives result_src 00, reg_write 1, `instr_done`. Goes to FETCH.
- BEQ:
  - Drives alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00.
  - `pc_write` equals `zero`.
  - Asserts `instr_done`. Goes to FETCH.
- JAL:
  - Drives alu_src_a 01, alu_src_b 10, add, result_src 00, pc_write 1. This loads the PC from ALUOut (target) while the ALU computes PC+4.
  - Goes to ALUWB, which writes rd.
- Outputs not listed for a state are 0, including select fields.

## Timing
- While `rst_n` = 0, the state is FETCH. `pc_write`, `ir_write`, `reg_write`, `mem_write`, `instr_done` and `illegal_instr` are forced to 0.
- Select outputs during reset show the FETCH values, with `alu_control` = 000.
- On deassertion, the first rising edge evaluates FETCH normally.
- Cycles per instruction with `mem_ready` held at 1:
  - lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal 2.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds one cycle. No write enable fires during those wait cycles, except that `mem_write` holds in MEMWRITE.
- `mem_ready` is ignored in every state except FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction returns to FETCH immediately and asynchronously. No partial writeback occurs.

## Test plan
- Reset then add: hold `rst_n` low 3 cycles with all enables 0. Feed add (op 0110011, f3 000, f7b5 0) with mem_ready = 1. Required state sequence FETCH→DECODE→EXECR→ALUWB, with alu_control 000 in EXECR and reg_write only in ALUWB.
- sub/sltu/or/and: R-type with f7b5 1 and f3 000 gives 001. R-type f3 011 gives 101, f3 110 gives 011, f3 111 gives 010. addi with f7b5 1 still gives 000.
- lw with `mem_ready` low 2 cycles in FETCH and 3 in MEMREAD: total 10 cycles. `ir_write` pulses once. reg_write with result_src 01 occurs only in MEMWB.
- sw with `mem_ready` low 1 cycle in MEMWRITE: `mem_write` high for 2 cycles, `instr_done` high only in the second.
- beq: with zero = 1, `pc_write` is 1 in BEQ and alu_control is 001. With zero = 0, `pc_write` is 0. jal: `pc_write` in JAL, then reg_write in ALUWB, 4 cycles total.
- Illegal and reset abort: op 0110111 pulses `illegal_instr` in DECODE, then FETCH. Pulsing `rst_n` low during MEMREAD returns to FETCH with no reg_write.
